// File: rtl/cramer_pkg.sv
// Shared widths, FSM states and operand-pass selector for the Cramer's-rule sequencer.
package cramer_pkg;

  localparam int COEF_W = 12;
  localparam int DET_W  = 24;

  typedef enum logic [2:0] {
    IDLE,
    CALC_D,
    CALC_DX,
    CALC_DY,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    PASS_D,
    PASS_DX,
    PASS_DY
  } pass_t;

endpackage

// File: rtl/determinant.sv
// Combinational 2x2 determinant x1*y2 - x2*y1 on 12-bit two's-complement operands.
module determinant (
  input  logic [11:0] x1,
  input  logic [11:0] y1,
  input  logic [11:0] x2,
  input  logic [11:0] y2,
  output logic [23:0] det
);

  logic signed [23:0] p_main;
  logic signed [23:0] p_cross;

  assign p_main  = 24'($signed(x1)) * 24'($signed(y2));
  assign p_cross = 24'($signed(x2)) * 24'($signed(y1));
  assign det     = p_main - p_cross;

endmodule

// File: rtl/cramer_solver_seq.sv
// Time-shares one determinant unit over three passes to produce D, Dx, Dy and a singular flag.
module cramer_solver_seq #(
  parameter int COEF_W        = cramer_pkg::COEF_W,
  parameter int DET_W         = cramer_pkg::DET_W,
  parameter bit SKIP_SINGULAR = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] a1,
  input  logic signed [COEF_W-1:0] b1,
  input  logic signed [COEF_W-1:0] c1,
  input  logic signed [COEF_W-1:0] a2,
  input  logic signed [COEF_W-1:0] b2,
  input  logic signed [COEF_W-1:0] c2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DET_W-1:0]  d,
  output logic signed [DET_W-1:0]  dx,
  output logic signed [DET_W-1:0]  dy,
  output logic                     singular
);

  import cramer_pkg::*;

  state_t state, state_next;
  pass_t  pass;

  logic signed [COEF_W-1:0] op_a1, op_b1, op_c1, op_a2, op_b2, op_c2;
  logic [COEF_W-1:0] x1, y1, x2, y2;
  logic [DET_W-1:0]  det_raw;
  logic              det_zero;
  logic              accept;
  logic              release_out;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid & in_ready;
  assign release_out = out_valid & out_ready;
  assign det_zero    = (det_raw == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC_D;
      CALC_D:  state_next = (SKIP_SINGULAR && det_zero) ? DONE : CALC_DX;
      CALC_DX: state_next = CALC_DY;
      CALC_DY: state_next = DONE;
      DONE:    if (release_out) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Coefficients are frozen at accept so the source may move on immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a1 <= '0;
      op_b1 <= '0;
      op_c1 <= '0;
      op_a2 <= '0;
      op_b2 <= '0;
      op_c2 <= '0;
    end else if (accept) begin
      op_a1 <= a1;
      op_b1 <= b1;
      op_c1 <= c1;
      op_a2 <= a2;
      op_b2 <= b2;
      op_c2 <= c2;
    end
  end

  always_comb begin
    pass = PASS_D;
    case (state)
      CALC_DX: pass = PASS_DX;
      CALC_DY: pass = PASS_DY;
      default: pass = PASS_D;
    endcase
  end

  // Dx replaces the x column with c, Dy replaces the y column with c.
  always_comb begin
    x1 = op_a1;
    y1 = op_b1;
    x2 = op_a2;
    y2 = op_b2;
    case (pass)
      PASS_DX: begin
        x1 = op_c1;
        x2 = op_c2;
      end
      PASS_DY: begin
        y1 = op_c1;
        y2 = op_c2;
      end
      default: ;
    endcase
  end

  determinant u_det (
    .x1  (x1),
    .y1  (y1),
    .x2  (x2),
    .y2  (y2),
    .det (det_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d        <= '0;
      dx       <= '0;
      dy       <= '0;
      singular <= 1'b0;
    end else begin
      case (state)
        CALC_D: begin
          d        <= $signed(det_raw);
          singular <= det_zero;
          if (SKIP_SINGULAR && det_zero) begin
            dx <= '0;
            dy <= '0;
          end
        end
        CALC_DX: dx <= $signed(det_raw);
        CALC_DY: dy <= $signed(det_raw);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cramer_solver_seq.sv
// Self-checking bench: table vectors, random jobs against a Cramer's-rule model, backpressure and reset cases.
module tb_cramer_solver_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic out_ready;
  logic signed [11:0] a1, b1, c1, a2, b2, c2;

  logic in_ready1, out_valid1, singular1;
  logic signed [23:0] d1, dx1, dy1;
  logic in_ready0, out_valid0, singular0;
  logic signed [23:0] d0, dx0, dy0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cramer_solver_seq #(.SKIP_SINGULAR(1'b1)) dut_skip (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a1(a1), .b1(b1), .c1(c1), .a2(a2), .b2(b2), .c2(c2),
    .out_valid(out_valid1), .out_ready(out_ready),
    .d(d1), .dx(dx1), .dy(dy1), .singular(singular1)
  );

  cramer_solver_seq #(.SKIP_SINGULAR(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a1(a1), .b1(b1), .c1(c1), .a2(a2), .b2(b2), .c2(c2),
    .out_valid(out_valid0), .out_ready(out_ready),
    .d(d0), .dx(dx0), .dy(dy0), .singular(singular0)
  );

  typedef struct {
    int a1, b1, c1, a2, b2, c2;
    int d, dx_skip, dy_skip, dx_full, dy_full;
    bit sing;
    int lat_skip, lat_full;
  } vec_t;

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cramer's rule straight from the system definition.
  function automatic void model(input int ka1, kb1, kc1, ka2, kb2, kc2, input bit skip,
                                output int md, mdx, mdy, output bit ms, output int mlat);
    md   = ka1 * kb2 - ka2 * kb1;
    mdx  = kc1 * kb2 - kc2 * kb1;
    mdy  = ka1 * kc2 - ka2 * kc1;
    ms   = (md == 0);
    mlat = 4;
    if (skip && ms) begin
      mdx  = 0;
      mdy  = 0;
      mlat = 2;
    end
  endfunction

  task automatic set_coefs(input int ka1, kb1, kc1, ka2, kb2, kc2);
    a1 = 12'(ka1); b1 = 12'(kb1); c1 = 12'(kc1);
    a2 = 12'(ka2); b2 = 12'(kb2); c2 = 12'(kc2);
  endtask

  task automatic scramble_coefs();
    set_coefs(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048,
              int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048,
              int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048);
  endtask

  // Called at #1 after an edge with both instances idle and out_ready high.
  task automatic apply_stimulus(input string tag, input vec_t v);
    int n_skip = -1;
    int n_full = -1;
    set_coefs(v.a1, v.b1, v.c1, v.a2, v.b2, v.c2);
    in_valid = 1'b1;
    check_output({tag, " in_ready skip pre"}, in_ready1, 1);
    check_output({tag, " in_ready full pre"}, in_ready0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_coefs();
    check_output({tag, " in_ready full busy"}, in_ready0, 0);
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (n_skip < 0 && out_valid1) begin
        n_skip = n;
        check_output({tag, " d skip"}, d1, v.d);
        check_output({tag, " dx skip"}, dx1, v.dx_skip);
        check_output({tag, " dy skip"}, dy1, v.dy_skip);
        check_output({tag, " singular skip"}, singular1, v.sing);
      end
      if (n_full < 0 && out_valid0) begin
        n_full = n;
        check_output({tag, " d full"}, d0, v.d);
        check_output({tag, " dx full"}, dx0, v.dx_full);
        check_output({tag, " dy full"}, dy0, v.dy_full);
        check_output({tag, " singular full"}, singular0, v.sing);
      end
      if (n_skip >= 0 && n_full >= 0) break;
    end
    check_output({tag, " latency skip"}, n_skip + 1, v.lat_skip);
    check_output({tag, " latency full"}, n_full + 1, v.lat_full);
    @(posedge clk); #1;
    check_output({tag, " in_ready skip post"}, in_ready1, 1);
    check_output({tag, " in_ready full post"}, in_ready0, 1);
  endtask

  vec_t table_v[$];
  vec_t rv;
  int   md, mdx1, mdy1, mdx0, mdy0, mlat1, mlat0;
  bit   ms;
  int   stray;

  initial begin
    table_v.push_back('{2, 3, 8, 1, -1, -1, -5, -5, -10, -5, -10, 1'b0, 4, 4});
    table_v.push_back('{1, 2, 3, 2, 4, 5, 0, 0, 0, 2, -1, 1'b1, 2, 4});
    table_v.push_back('{-2048, 2047, 0, -2048, -2048, 0, 8386560, 0, 0, 0, 0, 1'b0, 4, 4});
    table_v.push_back('{2047, -2048, 1, -2048, 2047, 1, -4095, 4095, 4095, 4095, 4095, 1'b0, 4, 4});
    table_v.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 2, 4});

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_coefs(0, 0, 0, 0, 0, 0);
    #12;
    check_output("reset d", d1, 0);
    check_output("reset dx", dx1, 0);
    check_output("reset dy", dy1, 0);
    check_output("reset singular", singular1, 0);
    check_output("reset out_valid", out_valid1, 0);
    check_output("reset in_ready", in_ready1, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (table_v[i]) apply_stimulus($sformatf("vec%0d", i), table_v[i]);

    // Random jobs; every fourth one is forced singular by scaling row 1.
    for (int i = 0; i < 30; i++) begin
      int ra1, rb1, rc1, ra2, rb2, rc2, k;
      rc1 = int'($urandom_range(4095)) - 2048;
      rc2 = int'($urandom_range(4095)) - 2048;
      if (i % 4 == 0) begin
        ra1 = int'($urandom_range(80)) - 40;
        rb1 = int'($urandom_range(80)) - 40;
        k   = int'($urandom_range(6)) - 3;
        ra2 = k * ra1;
        rb2 = k * rb1;
      end else begin
        ra1 = int'($urandom_range(4095)) - 2048;
        rb1 = int'($urandom_range(4095)) - 2048;
        ra2 = int'($urandom_range(4095)) - 2048;
        rb2 = int'($urandom_range(4095)) - 2048;
      end
      model(ra1, rb1, rc1, ra2, rb2, rc2, 1'b1, md, mdx1, mdy1, ms, mlat1);
      model(ra1, rb1, rc1, ra2, rb2, rc2, 1'b0, md, mdx0, mdy0, ms, mlat0);
      rv = '{ra1, rb1, rc1, ra2, rb2, rc2, md, mdx1, mdy1, mdx0, mdy0, ms, mlat1, mlat0};
      apply_stimulus($sformatf("rand%0d", i), rv);
    end

    // Backpressure: results must freeze and busy inputs must be ignored.
    out_ready = 1'b0;
    set_coefs(2, 3, 8, 1, -1, -1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("bp out_valid skip", out_valid1, 1);
    check_output("bp out_valid full", out_valid0, 1);
    for (int i = 0; i < 10; i++) begin
      scramble_coefs();
      in_valid = 1'b1;
      @(posedge clk); #1;
      check_output("bp hold out_valid", out_valid1, 1);
      check_output("bp hold in_ready", in_ready1, 0);
      check_output("bp hold d", d1, -5);
      check_output("bp hold dx", dx1, -5);
      check_output("bp hold dy", dy1, -10);
      check_output("bp hold full dy", dy0, -10);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_output("bp release out_valid", out_valid1, 0);
    check_output("bp release in_ready", in_ready1, 1);
    check_output("bp release in_ready full", in_ready0, 1);
    check_output("bp idle d held", d1, -5);

    // Reset while the job sits in CALC_DX.
    set_coefs(3, 1, 5, 1, 2, 4);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_output("rst d", d1, 0);
    check_output("rst dx", dx1, 0);
    check_output("rst dy", dy1, 0);
    check_output("rst singular", singular1, 0);
    check_output("rst in_ready", in_ready1, 1);
    check_output("rst out_valid", out_valid1, 0);
    check_output("rst d full", d0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid1 || out_valid0) stray++;
    end
    check_output("rst no stray out_valid", stray, 0);
    apply_stimulus("post-reset", table_v[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
